// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Bundles every signal between uart_rx_fifo and its neighbours: the write
//   side fed by uart_rx, the read side (valid/ready) used by the host, and
//   the status/flag outputs. Clock and reset are plain ports on the FIFO
//   itself and are not part of this interface.
//
//   Signals
//     i_rx_data       byte from uart_rx o_dout
//     i_rx_valid      1-cycle strobe from uart_rx o_valid
//     i_rx_error      uart_rx o_error, stored verbatim with the byte
//     o_dout          head-of-queue byte
//     o_err           error code stored with the head byte
//     o_valid         head entry present
//     i_ready         host accepts the head entry when o_valid && i_ready
//     o_count         number of stored entries, 0..DEPTH
//     o_empty         o_count == 0
//     o_full          o_count == DEPTH
//     o_almost_full   o_count >= AFULL_THRESH
//     o_overflow      sticky: at least one byte was dropped
//     i_clr_overflow  1-cycle pulse that clears o_overflow
//
//   Modports
//     slave   the FIFO (drives the o_* signals)
//     master  the surrounding logic / host (drives the i_* signals)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
);

   logic [DATA_WIDTH-1:0] i_rx_data;
   logic                  i_rx_valid;
   logic [1:0]            i_rx_error;
   logic [DATA_WIDTH-1:0] o_dout;
   logic [1:0]            o_err;
   logic                  o_valid;
   logic                  i_ready;
   logic [CNT_WIDTH-1:0]  o_count;
   logic                  o_empty;
   logic                  o_full;
   logic                  o_almost_full;
   logic                  o_overflow;
   logic                  i_clr_overflow;

   modport slave (
      input  i_rx_data, i_rx_valid, i_rx_error, i_ready, i_clr_overflow,
      output o_dout, o_err, o_valid, o_count, o_empty, o_full,
             o_almost_full, o_overflow
   );

   modport master (
      output i_rx_data, i_rx_valid, i_rx_error, i_ready, i_clr_overflow,
      input  o_dout, o_err, o_valid, o_count, o_empty, o_full,
             o_almost_full, o_overflow
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive buffer that sits directly behind uart_rx. Each {error, byte}
//   word is captured on the uart_rx valid strobe into a DEPTH-entry circular
//   buffer and handed to the host in first-word-fall-through order through a
//   valid/ready handshake. Fill level, almost-full watermark and a sticky
//   overflow flag are reported alongside. Single clock domain.
//
//   Parameters
//     DATA_WIDTH    payload width, equal to the uart_rx DATA_WIDTH
//     DEPTH         number of entries, power of two and >= 2
//     AFULL_THRESH  o_almost_full asserts when count >= AFULL_THRESH
//
//   Ports
//     i_clk   system clock, rising edge
//     i_rst   synchronous active-high reset
//     bus     uart_rx_fifo_if.slave (write side, read side and status)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic            i_clk,
   input  logic            i_rst,
   uart_rx_fifo_if.slave   bus
);

   localparam int CNT_WIDTH  = $clog2(DEPTH) + 1;
   localparam int ADDR_WIDTH = CNT_WIDTH - 1;
   localparam int WORD_WIDTH = DATA_WIDTH + 2;
   localparam logic [CNT_WIDTH-1:0] AFULL_C = CNT_WIDTH'(AFULL_THRESH);

   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [CNT_WIDTH-1:0]  wr_ptr;
   logic [CNT_WIDTH-1:0]  rd_ptr;
   logic [CNT_WIDTH-1:0]  count;
   logic                  overflow;
   logic                  empty;
   logic                  full;
   logic                  rd;
   logic                  wr;
   logic                  drop;

   // Pointers carry one extra wrap bit so that equal addresses can be told
   // apart as "empty" (wrap bits equal) or "full" (wrap bits differ).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[CNT_WIDTH-1] != rd_ptr[CNT_WIDTH-1]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

   // A full FIFO may still take a byte in the cycle its head is popped,
   // because the slot being freed is the one the write lands in.
   assign rd   = !empty && bus.i_ready;
   assign wr   = bus.i_rx_valid && (!full || rd);
   assign drop = bus.i_rx_valid && full && !rd;

   // Storage is deliberately not reset; nothing reads it while empty.
   always_ff @(posedge i_clk) begin
      if (!i_rst && wr) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.i_rx_error, bus.i_rx_data};
      end
   end

   // Pointer, count and overflow bookkeeping. Setting overflow on a drop
   // takes priority over a clear request arriving in the same cycle so a
   // lost byte is never silently forgotten.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + CNT_WIDTH'(1);
         end
         if (rd) begin
            rd_ptr <= rd_ptr + CNT_WIDTH'(1);
         end
         unique case ({wr, rd})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (bus.i_clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // Head word falls straight through from storage; every status output is
   // a function of registered state only, so i_rx_valid never reaches an
   // output combinationally.
   assign {bus.o_err, bus.o_dout} = mem[rd_ptr[ADDR_WIDTH-1:0]];
   assign bus.o_valid       = !empty;
   assign bus.o_empty       = empty;
   assign bus.o_full        = full;
   assign bus.o_count       = count;
   assign bus.o_almost_full = (count >= AFULL_C);
   assign bus.o_overflow    = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A queue-based reference model
//   tracks the expected contents and overflow flag; after every clock edge
//   all DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFULL = 12;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic i_clk;
   logic i_rst;

   uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .AFULL_THRESH(AFULL)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   // Free-running 10 ns clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int errors = 0;
   int checks = 0;

   // Reference model: queue of {err, data} words plus the sticky flag
   logic [DW+1:0] model_q [$];
   logic          model_ovf;
   int            seen_55;
   int            max_count;

   // The only comparison primitive; everything funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Compare every visible output with what the model predicts
   task automatic checkState(input string tag);
      int n;
      n = model_q.size();
      checkOutput({tag, ".count"},  32'(bus.o_count), 32'(n));
      checkOutput({tag, ".valid"},  32'(bus.o_valid), 32'(n != 0));
      checkOutput({tag, ".empty"},  32'(bus.o_empty), 32'(n == 0));
      checkOutput({tag, ".full"},   32'(bus.o_full),  32'(n == DEPTH));
      checkOutput({tag, ".afull"},  32'(bus.o_almost_full), 32'(n >= AFULL));
      checkOutput({tag, ".ovf"},    32'(bus.o_overflow), 32'(model_ovf));
      if (n != 0) begin
         checkOutput({tag, ".dout"}, 32'(bus.o_dout), 32'(model_q[0][DW-1:0]));
         checkOutput({tag, ".err"},  32'(bus.o_err),  32'(model_q[0][DW+1:DW]));
      end
      if (n > max_count) max_count = n;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then
   // sample the DUT 1 ns after the edge.
   task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                input logic [1:0] err, input logic ready,
                                input logic clr, input logic rst,
                                input string tag);
      int  n;
      bit  do_rd, do_wr, do_drop;
      bus.i_rx_valid     = valid;
      bus.i_rx_data      = data;
      bus.i_rx_error     = err;
      bus.i_ready        = ready;
      bus.i_clr_overflow = clr;
      i_rst              = rst;
      @(posedge i_clk);
      if (rst) begin
         model_q.delete();
         model_ovf = 1'b0;
      end else begin
         n       = model_q.size();
         do_rd   = (n > 0) && ready;
         do_wr   = valid && ((n < DEPTH) || do_rd);
         do_drop = valid && (n == DEPTH) && !do_rd;
         if (do_rd) void'(model_q.pop_front());
         if (do_wr) model_q.push_back({err, data});
         if (do_drop) model_ovf = 1'b1;
         else if (clr) model_ovf = 1'b0;
      end
      #1;
      if (bus.o_valid && bus.o_dout == 8'h55) seen_55++;
      checkState(tag);
   endtask

   task automatic idle(input logic ready, input string tag);
      applyStimulus(1'b0, 8'h00, 2'b00, ready, 1'b0, 1'b0, tag);
   endtask

   task automatic fillFrom(input int base);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 8'(base + i), 2'(i), 1'b0, 1'b0, 1'b0, "fill");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1, "drain");
   endtask

   initial begin
      model_ovf = 1'b0;
      seen_55   = 0;
      max_count = 0;
      bus.i_rx_valid     = 1'b0;
      bus.i_rx_data      = '0;
      bus.i_rx_error     = '0;
      bus.i_ready        = 1'b0;
      bus.i_clr_overflow = 1'b0;
      i_rst              = 1'b1;

      // Reset, with a write strobe present that must be ignored
      applyStimulus(1'b1, 8'hEE, 2'b11, 1'b0, 1'b0, 1'b1, "reset");
      applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, "reset2");

      // Single byte in and out; ready on an empty FIFO is harmless
      idle(1'b1, "rdy_empty");
      applyStimulus(1'b1, 8'hA6, 2'b00, 1'b0, 1'b0, 1'b0, "wr_a6");
      checkOutput("a6_dout", 32'(bus.o_dout), 32'h0000_00A6);
      checkOutput("a6_count", 32'(bus.o_count), 32'd1);
      idle(1'b0, "hold");
      idle(1'b1, "rd_a6");
      checkOutput("a6_empty", 32'(bus.o_empty), 32'd1);

      // Fill to full, watching almost_full and full rise in step
      fillFrom(0);
      checkOutput("full_count", 32'(bus.o_count), 32'd16);

      // Overflow: dropped byte, count frozen, then clear
      applyStimulus(1'b1, 8'h55, 2'b00, 1'b0, 1'b0, 1'b0, "drop55");
      checkOutput("ovf_set", 32'(bus.o_overflow), 32'd1);
      applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "clr");
      checkOutput("ovf_clr", 32'(bus.o_overflow), 32'd0);

      // Drop and clear together: set must win
      applyStimulus(1'b1, 8'h56, 2'b01, 1'b0, 1'b1, 1'b0, "drop_clr");
      applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "clr2");

      // Full with simultaneous read and write: accepted, 0x77 ends last
      applyStimulus(1'b1, 8'h77, 2'b10, 1'b1, 1'b0, 1'b0, "full_rw");
      checkOutput("rw_count", 32'(bus.o_count), 32'd16);
      drain();
      checkOutput("no55", 32'(seen_55), 32'd0);

      // Write into empty with ready held high the same cycle
      applyStimulus(1'b1, 8'h3C, 2'b01, 1'b1, 1'b0, 1'b0, "wr_empty_rdy");
      drain();

      // Randomised traffic with back-pressure and occasional clears
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom),
                       2'($urandom), 1'($urandom_range(0, 99) < 45),
                       1'($urandom_range(0, 99) < 5), 1'b0, "rand");
      end
      checkOutput("max_count", 32'(max_count <= DEPTH), 32'd1);

      // Reset with three entries stored discards them
      drain();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'(8'h90 + i), 2'b00, 1'b0, 1'b0, 1'b0, "pre_rst");
      end
      applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, "mid_rst");
      checkOutput("rst_count", 32'(bus.o_count), 32'd0);
      applyStimulus(1'b1, 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, "post_rst");
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
